// File: rtl/serial_sub_pkg.sv
// Shared types and sizing helpers for the bit-serial subtractor.
package serial_sub_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int unsigned WIDTH_DEF = 4;
    localparam int unsigned CNT_W     = $clog2(WIDTH_DEF);

    // Bit-counter width for an arbitrary operand width (never below one bit).
    function automatic int unsigned cnt_width(input int unsigned width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/full_subtractor.sv
// Single-bit full subtractor: d = a - b - bin, with borrow out.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    always_comb begin
        d    = a ^ b ^ bin;
        bout = (~a & b) | (~(a ^ b) & bin);
    end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor (diff = a - b - bin), LSB first, one cell plus a borrow FF.
// Optional two's-complement overflow output enabled by defining SERIAL_SUB_OVF_EN.
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
`ifdef SERIAL_SUB_OVF_EN
    output logic             bout,
    output logic             ovf
`else
    output logic             bout
`endif
);

    localparam int unsigned CNT_BITS = cnt_width(WIDTH);
    localparam logic [CNT_BITS-1:0] CNT_LAST = CNT_BITS'(WIDTH - 1);

    state_t              state, state_nxt;
    logic [CNT_BITS-1:0] cnt, cnt_nxt;
    logic [WIDTH-1:0]    a_sh, a_sh_nxt;
    logic [WIDTH-1:0]    b_sh, b_sh_nxt;
    logic                brw, brw_nxt;
    logic [WIDTH-1:0]    diff_nxt;
    logic                bout_nxt;
    logic                fs_d;
    logic                fs_bout;
`ifdef SERIAL_SUB_OVF_EN
    logic                ovf_nxt;
`endif

    full_subtractor u_fs (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .bin  (brw),
        .d    (fs_d),
        .bout (fs_bout)
    );

    // Next-state and datapath update
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        a_sh_nxt  = a_sh;
        b_sh_nxt  = b_sh;
        brw_nxt   = brw;
        diff_nxt  = diff;
        bout_nxt  = bout;
`ifdef SERIAL_SUB_OVF_EN
        ovf_nxt   = ovf;
`endif
        case (state)
            IDLE: begin
                if (in_valid) begin
                    a_sh_nxt  = a;
                    b_sh_nxt  = b;
                    brw_nxt   = bin;
                    cnt_nxt   = '0;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                diff_nxt = {fs_d, diff[WIDTH-1:1]};
                a_sh_nxt = a_sh >> 1;
                b_sh_nxt = b_sh >> 1;
                brw_nxt  = fs_bout;
                cnt_nxt  = cnt + CNT_BITS'(1);
                if (cnt == CNT_LAST) begin
                    // brw here is the borrow into the MSB
                    bout_nxt  = fs_bout;
`ifdef SERIAL_SUB_OVF_EN
                    ovf_nxt   = brw ^ fs_bout;
`endif
                    cnt_nxt   = '0;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            a_sh      <= '0;
            b_sh      <= '0;
            brw       <= 1'b0;
            diff      <= '0;
            bout      <= 1'b0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
`ifdef SERIAL_SUB_OVF_EN
            ovf       <= 1'b0;
`endif
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            a_sh      <= a_sh_nxt;
            b_sh      <= b_sh_nxt;
            brw       <= brw_nxt;
            diff      <= diff_nxt;
            bout      <= bout_nxt;
            out_valid <= (state_nxt == DONE);
            in_ready  <= (state_nxt == IDLE);
`ifdef SERIAL_SUB_OVF_EN
            ovf       <= ovf_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=4); overflow checks under SERIAL_SUB_OVF_EN.
module tb_serial_subtractor;

    localparam int unsigned W = 4;

    typedef struct packed {
        logic [W-1:0] diff;
        logic         bout;
        logic         ovf;
    } exp_t;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] diff;
    logic         bout;
`ifdef SERIAL_SUB_OVF_EN
    logic         ovf;
`endif

    int   checks;
    int   errors;
    exp_t sb_q[$];

    serial_subtractor #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
`ifdef SERIAL_SUB_OVF_EN
        .bout      (bout),
        .ovf       (ovf)
`else
        .bout      (bout)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: unsigned borrow and signed overflow from plain integer arithmetic.
    function automatic exp_t model(input logic [W-1:0] av, input logic [W-1:0] bv, input logic bv_in);
        exp_t e;
        int   u;
        int   s;
        u = int'(av) - int'(bv) - int'(bv_in);
        s = int'($signed(av)) - int'($signed(bv)) - int'(bv_in);
        e.diff = W'(u);
        e.bout = (u < 0);
        e.ovf  = (s < -(2 ** (W - 1))) || (s > (2 ** (W - 1)) - 1);
        return e;
    endfunction

    // Called at a negedge with the block idle; returns just after the accept edge.
    task automatic start_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic bv_in);
        in_valid = 1'b1;
        a        = av;
        b        = bv;
        bin      = bv_in;
        check("in_ready_idle", 32'(in_ready), 32'd1);
        sb_q.push_back(model(av, bv, bv_in));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a        = W'($urandom);
        b        = W'($urandom);
        bin      = 1'($urandom);
    endtask

    // Waits for the result, holds it for 'hold' cycles, then completes the handshake.
    task automatic finish_op(input int hold, input bit noise);
        exp_t e;
        int   lat;
        lat = 0;
        do begin
            if (noise) begin
                in_valid  = 1'($urandom);
                a         = W'($urandom);
                b         = W'($urandom);
                out_ready = 1'($urandom);
            end
            @(negedge clk);
            lat++;
        end while (!out_valid && lat < 20);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("latency", 32'(lat), 32'd5);
        if (sb_q.size() == 0) begin
            check("scoreboard_empty", 32'(sb_q.size()), 32'd1);
            return;
        end
        e = sb_q.pop_front();
        for (int h = 0; h < hold; h++) begin
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_in_ready", 32'(in_ready), 32'd0);
            check("hold_diff", 32'(diff), 32'(e.diff));
            check("hold_bout", 32'(bout), 32'(e.bout));
            @(negedge clk);
        end
        check("diff", 32'(diff), 32'(e.diff));
        check("bout", 32'(bout), 32'(e.bout));
        check("out_valid", 32'(out_valid), 32'd1);
        check("in_ready_done", 32'(in_ready), 32'd0);
`ifdef SERIAL_SUB_OVF_EN
        check("ovf", 32'(ovf), 32'(e.ovf));
`endif
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        check("in_ready_after", 32'(in_ready), 32'd1);
        check("out_valid_after", 32'(out_valid), 32'd0);
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        clk       = 1'b0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        bin       = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_diff", 32'(diff), 32'd0);
        check("rst_bout", 32'(bout), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);

        // Zero operands, latency check
        start_op(4'b0000, 4'b0000, 1'b0);
        finish_op(0, 1'b0);

        // Back-to-back ordinary operations
        start_op(4'b1010, 4'b0101, 1'b0);
        finish_op(0, 1'b0);
        start_op(4'b1100, 4'b1010, 1'b1);
        finish_op(0, 1'b1);

        // Wrap-around cases
        start_op(4'b0000, 4'b0001, 1'b0);
        finish_op(0, 1'b0);
        start_op(4'b1111, 4'b1111, 1'b1);
        finish_op(0, 1'b1);

        // Downstream stall held for 10 cycles
        start_op(4'b0110, 4'b1001, 1'b0);
        finish_op(10, 1'b0);

        // Reset two bits into a shift discards the operation
        start_op(4'b1011, 4'b0110, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        sb_q.delete();
        @(negedge clk);
        check("mid_rst_diff", 32'(diff), 32'd0);
        check("mid_rst_bout", 32'(bout), 32'd0);
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_in_ready", 32'(in_ready), 32'd1);
`ifdef SERIAL_SUB_OVF_EN
        check("mid_rst_ovf", 32'(ovf), 32'd0);
`endif
        start_op(4'b0111, 4'b0011, 1'b0);
        finish_op(0, 1'b0);

`ifdef SERIAL_SUB_OVF_EN
        start_op(4'b1000, 4'b0001, 1'b0);
        finish_op(0, 1'b0);
        start_op(4'b0111, 4'b1111, 1'b0);
        finish_op(0, 1'b0);
        start_op(4'b0101, 4'b0011, 1'b0);
        finish_op(0, 1'b0);
`endif

        // Random sweep against the reference model
        for (int i = 0; i < 40; i++) begin
            start_op(W'($urandom), W'($urandom), 1'($urandom));
            finish_op(int'($urandom_range(0, 2)), 1'b1);
        end

        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
